// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA stream controller: controller state encoding,
// bytes-per-block derivation and the default watchdog limit.
package rsa_pkg;

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        CHECK   = 3'd1,
        LAUNCH  = 3'd2,
        WAIT    = 3'd3,
        SEND    = 3'd4
    } rsa_state_e;

    // Number of bytes in one 2*width-bit block (width is a multiple of 4).
    function automatic int nBytes(input int width);
        return (2 * width) / 8;
    endfunction

    // Default watchdog limit, in cycles spent waiting for the engine.
    function automatic int defaultTimeout(input int width);
        return 4 * width + 8;
    endfunction

endpackage

// File: rtl/rsa_byte_ser.sv
// Parallel-load 2*WIDTH -> 8 bit shift serialiser with a valid/ready output
// and a one-cycle done flag that marks the handshake of the final byte.
module rsa_byte_ser
    import rsa_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_i,
    input  logic [2*WIDTH-1:0] loadData_i,
    input  logic               ready_i,
    output logic [7:0]         data_o,
    output logic               valid_o,
    output logic               done_o
);

    localparam int NBYTES = nBytes(WIDTH);
    localparam int CW     = $clog2(NBYTES + 1);

    logic [2*WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               fire;
    logic               lastByte;

    assign fire     = valid_q && ready_i;
    assign lastByte = (cnt_q == CW'(NBYTES - 1));
    assign data_o   = res_q[2*WIDTH-1 -: 8];
    assign valid_o  = valid_q;
    assign done_o   = fire && lastByte;

    // Load a new result, or shift out one byte per accepted handshake.
    always_comb begin
        res_d   = res_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            res_d   = loadData_i;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (fire) begin
            res_d = res_q << 8;
            if (lastByte) begin
                cnt_d   = '0;
                valid_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Serialiser registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/rsa_stream_ctrl.sv
// Byte-stream front/back end for the RSA modular-exponentiation engine.
// Collects a block, range-checks it against the modulus, launches the engine,
// waits for finish and serialises the result.
// Optional macro RSA_STREAM_CTRL_TIMEOUT_EN adds a WAIT watchdog and the
// err_timeout output.
module rsa_stream_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = 32
`ifdef RSA_STREAM_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT = defaultTimeout(WIDTH)
`endif
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2*WIDTH-1:0] key_n,
    input  logic [2*WIDTH-1:0] key_e,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               me_start,
    output logic [2*WIDTH-1:0] me_base,
    output logic [2*WIDTH-1:0] me_modulo,
    output logic [2*WIDTH-1:0] me_exponent,
    input  logic               me_finish,
    input  logic [2*WIDTH-1:0] me_result,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               err_range,
`ifdef RSA_STREAM_CTRL_TIMEOUT_EN
    output logic               err_timeout,
`endif
    output logic               busy
);

    localparam int NBYTES = nBytes(WIDTH);
    localparam int CW     = $clog2(NBYTES + 1);
    localparam logic [2*WIDTH-1:0] KEY_MIN = (2*WIDTH)'(2);

    rsa_state_e         state_q, state_d;
    logic [2*WIDTH-1:0] blk_q, blk_d;
    logic [CW-1:0]      byteCnt_q, byteCnt_d;
    logic [2*WIDTH-1:0] base_q, base_d;
    logic [2*WIDTH-1:0] modulo_q, modulo_d;
    logic [2*WIDTH-1:0] exponent_q, exponent_d;
    logic               waitArmed_q, waitArmed_d;

    logic [2*WIDTH-1:0] blkShifted;
    logic               inFire;
    logic               lastByte;
    logic               reject;
    logic               finishAccept;
    logic               serDone;
    logic               timeoutHit;

    assign inFire       = in_valid && in_ready;
    assign lastByte     = (byteCnt_q == CW'(NBYTES - 1));
    assign reject       = (blk_q >= key_n) || (key_n < KEY_MIN);
    assign finishAccept = (state_q == WAIT) && waitArmed_q && me_finish;

    assign me_base     = base_q;
    assign me_modulo   = modulo_q;
    assign me_exponent = exponent_q;

    if (2*WIDTH > 8) begin : gShift
        assign blkShifted = {blk_q[2*WIDTH-9:0], in_data};
    end else begin : gNoShift
        assign blkShifted = in_data;
    end

`ifdef RSA_STREAM_CTRL_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wdCnt_q, wdCnt_d;

    assign timeoutHit = (state_q == WAIT) && !finishAccept && (wdCnt_q == WDW'(TIMEOUT - 1));

    // Watchdog counts cycles spent in WAIT and clears everywhere else.
    always_comb begin
        wdCnt_d = (state_q == WAIT) ? wdCnt_q + WDW'(1) : '0;
    end

    // Watchdog register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wdCnt_q <= '0;
        else          wdCnt_q <= wdCnt_d;
    end
`else
    assign timeoutHit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= COLLECT;
        else          state_q <= state_d;
    end

    // Next-state logic for the collect/check/launch/wait/send sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (inFire && lastByte) state_d = CHECK;
            CHECK:   state_d = reject ? COLLECT : LAUNCH;
            LAUNCH:  state_d = WAIT;
            WAIT: begin
                if (finishAccept)    state_d = SEND;
                else if (timeoutHit) state_d = COLLECT;
            end
            SEND:    if (serDone) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // State-decoded outputs: handshake, engine start, error pulses, busy.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b1;
        me_start  = 1'b0;
        err_range = 1'b0;
`ifdef RSA_STREAM_CTRL_TIMEOUT_EN
        err_timeout = timeoutHit;
`endif
        case (state_q)
            COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            CHECK:   err_range = reject;
            LAUNCH:  me_start  = 1'b1;
            default: ;
        endcase
    end

    // Datapath: shift in bytes, latch keys in CHECK, arm finish after first WAIT cycle.
    always_comb begin
        blk_d       = blk_q;
        byteCnt_d   = byteCnt_q;
        base_d      = base_q;
        modulo_d    = modulo_q;
        exponent_d  = exponent_q;
        waitArmed_d = (state_q == WAIT);
        if (inFire) begin
            blk_d     = blkShifted;
            byteCnt_d = lastByte ? '0 : byteCnt_q + CW'(1);
        end
        if (state_q == CHECK) begin
            modulo_d   = key_n;
            exponent_d = key_e;
            if (!reject) base_d = blk_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_q       <= '0;
            byteCnt_q   <= '0;
            base_q      <= '0;
            modulo_q    <= '0;
            exponent_q  <= '0;
            waitArmed_q <= 1'b0;
        end else begin
            blk_q       <= blk_d;
            byteCnt_q   <= byteCnt_d;
            base_q      <= base_d;
            modulo_q    <= modulo_d;
            exponent_q  <= exponent_d;
            waitArmed_q <= waitArmed_d;
        end
    end

    rsa_byte_ser #(
        .WIDTH (WIDTH)
    ) uSer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (finishAccept),
        .loadData_i (me_result),
        .ready_i    (out_ready),
        .data_o     (out_data),
        .valid_o    (out_valid),
        .done_o     (serDone)
    );

endmodule
